// File: rtl/ucs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ucs_pkg: shared FSM state type, derived-width helpers and reciprocal-table helpers
// for the clause select engine.
package ucs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } ucs_state_e;

  // Contents of this file equal the table ucs_recip() builds at elaboration.
  localparam string RECIP_ROM_FILE = "M_table_roundup.mem";

  function automatic int ucs_addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ucs_clause_width(input int nsat, input int lit_width);
    return nsat * lit_width;
  endfunction

  // ceil(2^mw / m); entry 0 is unused because an empty buffer never divides.
  function automatic logic [63:0] ucs_recip(input int m, input int mw);
    logic [63:0] num;
    if (m <= 0) return '0;
    num = (64'd1 << mw) + 64'(m) - 64'd1;
    return num / 64'(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ucs_dp_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ucs_dp_ram: clause buffer storage, port A read/write and port B read-only,
// both with one cycle of read latency and no reset on the array.
module ucs_dp_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 36,
  parameter int AW    = 11
) (
  input  logic             clk_i,
  input  logic             a_we_i,
  input  logic [AW-1:0]    a_addr_i,
  input  logic [WIDTH-1:0] a_wdata_i,
  output logic [WIDTH-1:0] a_rdata_o,
  input  logic [AW-1:0]    b_addr_i,
  output logic [WIDTH-1:0] b_rdata_o
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (a_we_i) mem[a_addr_i] <= a_wdata_i;
    a_rdata_o <= mem[a_addr_i];
    b_rdata_o <= mem[b_addr_i];
  end

endmodule
`default_nettype wire

// File: rtl/ucs_select_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ucs_select_engine: clause buffer with uniform random select-and-remove (R mod m via reciprocal).
// Define UCS_PEAK_COUNT_EN to add peak_count_o (maximum occupancy since reset or SETUP entry).
module ucs_select_engine
  import ucs_pkg::*;
#(
  parameter int BUFFER_DEPTH          = 2048,
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 12,
  parameter int RANDOM_NUM_WIDTH      = 18,
  parameter int M_TABLE_WIDTH         = 32,
  localparam int AW = ucs_addr_width(BUFFER_DEPTH),
  localparam int CW = ucs_clause_width(NSAT, LITERAL_ADDRESS_WIDTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        setup_i,
  input  logic                        ins_valid_i,
  output logic                        ins_ready_o,
  input  logic [CW-1:0]               ins_clause_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [RANDOM_NUM_WIDTH-1:0] random_i,
  output logic                        sel_valid_o,
  output logic [CW-1:0]               sel_clause_o,
  output logic [AW-1:0]               sel_index_o,
  output logic                        sel_empty_o,
`ifdef UCS_PEAK_COUNT_EN
  output logic [AW:0]                 peak_count_o,
`endif
  output logic [AW:0]                 count_o,
  output logic                        full_o,
  output logic                        overflow_o
);

  localparam int RW   = RANDOM_NUM_WIDTH;
  localparam int MW   = M_TABLE_WIDTH;
  localparam int PW   = RW + MW + 1;
  localparam int DW   = RW + AW + 2;
  localparam int RECW = MW + 1;

  ucs_state_e state, state_next;
  logic [AW:0]    count, m_last, cnt_m1;
  logic           overflow, full, busy, ins_fire, req_fire, enter_setup, m_empty, swap;
  logic           vld1, vld2, vld3, vld4;
  logic [RW-1:0]  cap_rnd;
  logic [AW:0]    cap_m;
  logic [PW-1:0]  prod, prod_next;
  logic [DW-1:0]  quot, rem_raw, rem_fix;
  logic [AW-1:0]  sel_idx, idx_next, a_addr, b_addr;
  logic           a_we;
  logic [CW-1:0]  a_wdata, a_rdata, b_rdata;
  logic           unused_bits;

  assign busy        = vld1 | vld2 | vld3 | vld4;
  assign full        = (count == (AW+1)'(BUFFER_DEPTH));
  assign ins_ready_o = (state != ST_IDLE) & ~full & ~busy;
  assign ins_fire    = ins_valid_i & ins_ready_o;
  // An insert in the same cycle wins; the request then samples the grown count.
  assign req_ready_o = (state == ST_RUN) & ~busy & ~setup_i & ~ins_fire;
  assign req_fire    = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (setup_i) state_next = ST_SETUP;
      ST_SETUP: if (!setup_i) state_next = ST_RUN;
      ST_RUN:   if (setup_i && !busy) state_next = ST_SETUP;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign enter_setup = (state_next == ST_SETUP) && (state != ST_SETUP);

  logic [RECW-1:0] recip_rom [0:BUFFER_DEPTH];
  for (genvar g = 0; g <= BUFFER_DEPTH; g++) begin : g_recip
    assign recip_rom[g] = RECW'(ucs_recip(g, MW));
  end

  assign prod_next = PW'(cap_rnd) * PW'(recip_rom[cap_m]);
  assign quot      = DW'(prod[PW-1:MW]);
  assign rem_raw   = DW'(cap_rnd) - quot * DW'(cap_m);
  assign rem_fix   = (rem_raw >= DW'(cap_m)) ? rem_raw - DW'(cap_m) : rem_raw;
  assign idx_next  = (cap_m <= (AW+1)'(1)) ? '0 : rem_fix[AW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld1    <= 1'b0;
      vld2    <= 1'b0;
      vld3    <= 1'b0;
      vld4    <= 1'b0;
      cap_rnd <= '0;
      cap_m   <= '0;
      prod    <= '0;
      sel_idx <= '0;
    end else begin
      vld1 <= req_fire;
      vld2 <= vld1;
      vld3 <= vld2;
      vld4 <= vld3;
      if (req_fire) begin
        cap_rnd <= random_i;
        cap_m   <= count;
      end
      if (vld1) prod <= prod_next;
      if (vld2) sel_idx <= idx_next;
    end
  end

  assign m_empty = (cap_m == '0);
  assign m_last  = cap_m - (AW+1)'(1);
  assign swap    = vld4 & ~m_empty & (sel_idx != m_last[AW-1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (ins_fire)               count <= count + (AW+1)'(1);
      else if (vld4 && !m_empty)  count <= m_last;
      if (enter_setup)            overflow <= 1'b0;
      else if (ins_valid_i && full) overflow <= 1'b1;
    end
  end

  // Port A: insert write, else swap write in cycle 4, else read at the selected index.
  always_comb begin
    a_we    = 1'b0;
    a_addr  = sel_idx;
    a_wdata = b_rdata;
    if (ins_fire) begin
      a_we    = 1'b1;
      a_addr  = count[AW-1:0];
      a_wdata = ins_clause_i;
    end else if (swap) begin
      a_we = 1'b1;
    end
  end

  assign cnt_m1 = count - (AW+1)'(1);
  assign b_addr = cnt_m1[AW-1:0];

  ucs_dp_ram #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (CW),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .a_we_i    (a_we),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .a_rdata_o (a_rdata),
    .b_addr_i  (b_addr),
    .b_rdata_o (b_rdata)
  );

  assign sel_valid_o  = vld4;
  assign sel_empty_o  = vld4 & m_empty;
  assign sel_clause_o = (vld4 && !m_empty) ? a_rdata : '0;
  assign sel_index_o  = vld4 ? sel_idx : '0;
  assign count_o      = count;
  assign full_o       = full;
  assign overflow_o   = overflow;

`ifdef UCS_PEAK_COUNT_EN
  logic [AW:0] peak;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            peak <= '0;
    else if (enter_setup)   peak <= count;
    else if (count > peak)  peak <= count;
  end
  assign peak_count_o = peak;
`endif

  assign unused_bits = ^{prod[MW-1:0], rem_fix[DW-1:AW], m_last[AW], cnt_m1[AW]};

endmodule
`default_nettype wire

// File: tb/tb_ucs_select_engine.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ucs_select_engine: directed checks of insert, select/remove, empty, full/overflow and reset.
module tb_ucs_select_engine;

  localparam int AW = 11;
  localparam int CW = 36;

  logic clk;
  logic rst_n, setup, ins_valid, ins_ready, req_valid, req_ready;
  logic [CW-1:0] ins_clause, sel_clause;
  logic [17:0] random_i;
  logic sel_valid, sel_empty, full, overflow;
  logic [AW-1:0] sel_index;
  logic [AW:0] count;

  logic rst2_n, setup2, ins_valid2, ins_ready2, req_valid2, req_ready2;
  logic [CW-1:0] ins_clause2, sel_clause2;
  logic [17:0] random2;
  logic sel_valid2, sel_empty2, full2, overflow2;
  logic [1:0] sel_index2;
  logic [2:0] count2;
`ifdef UCS_PEAK_COUNT_EN
  logic [AW:0] peak;
  logic [2:0] peak2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] model [0:2047];
  int mcount = 0;

  ucs_select_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .setup_i(setup),
    .ins_valid_i(ins_valid), .ins_ready_o(ins_ready), .ins_clause_i(ins_clause),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .random_i(random_i),
    .sel_valid_o(sel_valid), .sel_clause_o(sel_clause), .sel_index_o(sel_index),
    .sel_empty_o(sel_empty),
`ifdef UCS_PEAK_COUNT_EN
    .peak_count_o(peak),
`endif
    .count_o(count), .full_o(full), .overflow_o(overflow)
  );

  ucs_select_engine #(.BUFFER_DEPTH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst2_n), .setup_i(setup2),
    .ins_valid_i(ins_valid2), .ins_ready_o(ins_ready2), .ins_clause_i(ins_clause2),
    .req_valid_i(req_valid2), .req_ready_o(req_ready2), .random_i(random2),
    .sel_valid_o(sel_valid2), .sel_clause_o(sel_clause2), .sel_index_o(sel_index2),
    .sel_empty_o(sel_empty2),
`ifdef UCS_PEAK_COUNT_EN
    .peak_count_o(peak2),
`endif
    .count_o(count2), .full_o(full2), .overflow_o(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_insert(input logic [CW-1:0] c);
    ins_clause = c;
    ins_valid  = 1'b1;
    @(negedge clk);
    ins_valid  = 1'b0;
    model[mcount] = c;
    mcount++;
  endtask

  // Returns the number of negedges from accept to sel_valid (4 expected) plus the result.
  task automatic do_select(input logic [17:0] r, input bit raise_setup, output int lat,
                           output logic [CW-1:0] cl, output logic [AW-1:0] ix, output logic em);
    int guard;
    random_i  = r;
    req_valid = 1'b1;
    #1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_accept", guard < 20, 1);
    @(negedge clk);
    req_valid = 1'b0;
    random_i  = '0;
    lat = 1;
    while (!sel_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if (raise_setup && lat == 2) setup = 1'b1;
    end
    cl = sel_clause;
    ix = sel_index;
    em = sel_empty;
    @(negedge clk);
  endtask

  task automatic sel_model(input int r, input bit raise_setup);
    int m, ei, lat;
    logic [CW-1:0] cl;
    logic [AW-1:0] ix;
    logic em;
    m = mcount;
    do_select(18'(r), raise_setup, lat, cl, ix, em);
    ei = r % m;
    check("sweep_lat", lat, 4);
    check("sweep_idx", ix, ei);
    check("sweep_clause", cl, model[ei]);
    model[ei] = model[m-1];
    mcount = m - 1;
    check("sweep_count", count, mcount);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [CW-1:0] cl;
    logic [AW-1:0] ix;
    logic em;

    rst_n = 0; setup = 0; ins_valid = 0; ins_clause = '0; req_valid = 0; random_i = '0;
    rst2_n = 0; setup2 = 0; ins_valid2 = 0; ins_clause2 = '0; req_valid2 = 0; random2 = '0;
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_ins_ready", ins_ready, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_sel_clause", sel_clause, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1; rst2_n = 1;
    @(negedge clk);
    check("idle_ins_ready", ins_ready, 0);

    // Five inserts A..E in SETUP, then R=13 with m=5 selects index 3 (D).
    setup = 1;
    @(negedge clk);
    do_insert(36'hA_0000_000A);
    do_insert(36'hB_0000_000B);
    do_insert(36'hC_0000_000C);
    do_insert(36'hD_0000_000D);
    do_insert(36'hE_0000_000E);
    setup = 0;
    @(negedge clk);
    check("load_count", count, 5);
    do_select(18'd13, 0, lat, cl, ix, em);
    check("r13_lat", lat, 4);
    check("r13_idx", ix, 3);
    check("r13_clause", cl, 36'hD_0000_000D);
    check("r13_empty", em, 0);
    check("r13_count", count, 4);
    do_select(18'd3, 0, lat, cl, ix, em);       // entry[3] must now hold E
    check("swap_idx", ix, 3);
    check("swap_clause", cl, 36'hE_0000_000E);
    check("swap_count", count, 3);
    do_select(18'd262143, 0, lat, cl, ix, em);  // 262143 mod 3 = 0, C moves to 0
    check("m3_idx", ix, 0);
    check("m3_clause", cl, 36'hA_0000_000A);
    do_select(18'd1, 0, lat, cl, ix, em);
    check("m2_idx", ix, 1);
    check("m2_clause", cl, 36'hB_0000_000B);
    do_select(18'd262143, 0, lat, cl, ix, em);
    check("m1_idx", ix, 0);
    check("m1_clause", cl, 36'hC_0000_000C);
    check("m1_count", count, 0);
    do_select(18'd5, 0, lat, cl, ix, em);
    check("empty_lat", lat, 4);
    check("empty_flag", em, 1);
    check("empty_clause", cl, 0);
    check("empty_count", count, 0);

    // Same-cycle insert and request: insert wins, request sees count 1.
    ins_clause = 36'h5_1234_5678;
    ins_valid  = 1'b1;
    random_i   = 18'd0;
    req_valid  = 1'b1;
    #1;
    check("prio_req_blocked", req_ready, 0);
    check("prio_ins_ready", ins_ready, 1);
    @(negedge clk);
    ins_valid = 1'b0;
    do_select(18'd0, 0, lat, cl, ix, em);
    check("prio_empty", em, 0);
    check("prio_clause", cl, 36'h5_1234_5678);
    check("prio_count", count, 0);
    mcount = 0;

    // m = 7 sweep over boundary and spread R values, refilling after each select.
    for (int i = 0; i < 7; i++) do_insert(36'h7000 + 36'(i));
    for (int r = 0; r < 14; r++) begin
      sel_model(r, 0);
      do_insert(36'h8000 + 36'(r));
    end
    for (int r = 262130; r < 262144; r++) begin
      sel_model(r, 0);
      do_insert(36'h9000 + 36'(r));
    end
    for (int i = 0; i < 40; i++) begin
      sel_model(i * 6571, 0);
      do_insert(36'hA000 + 36'(i));
    end

    // setup_i rising mid-select: the select still completes.
    sel_model(100, 1);
    @(negedge clk);
    check("setup_req_ready", req_ready, 0);
    setup = 0;
    repeat (2) @(negedge clk);
    check("run_req_ready", req_ready, 1);

    // Reset in cycle 2 of a select.
    random_i  = 18'd9;
    req_valid = 1'b1;
    #1;
    check("midrst_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_sel_valid", sel_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_ins_ready", ins_ready, 0);
    check("midrst_sel_index", sel_index, 0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (sel_valid) seen = 1;
    end
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (sel_valid) seen = 1;
    end
    check("midrst_no_result", seen, 0);

    // Depth-4 instance: fill, overflow, sticky in RUN, cleared on SETUP entry.
    setup2 = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ins_clause2 = 36'(i + 1);
      ins_valid2  = 1'b1;
      @(negedge clk);
    end
    check("d4_full", full2, 1);
    check("d4_count", count2, 4);
    check("d4_ins_ready", ins_ready2, 0);
    check("d4_ovf_before", overflow2, 0);
    @(negedge clk);
    ins_valid2 = 1'b0;
    check("d4_overflow", overflow2, 1);
    check("d4_count_hold", count2, 4);
    setup2 = 0;
    repeat (2) @(negedge clk);
    check("d4_ovf_sticky", overflow2, 1);
    setup2 = 1;
    @(negedge clk);
    check("d4_ovf_clear", overflow2, 0);
    check("d4_count_keep", count2, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
